// File: rtl/audio_dac_stream.sv
// audio_dac_stream: FIFO-buffered stereo serialiser for a codec-mastered I2S / left-justified DAC link.
// One pair is fetched per frame at the left slot start; bits shift out on synchronised BCLK falling edges.
module audio_dac_stream #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int I2S_MODE     = 1
) (
    input  logic                        CLOCK_50,
    input  logic                        reset_n,
    input  logic                        clear_audio_out_memory,
    input  logic [SAMPLE_WIDTH-1:0]     left_channel_audio_out,
    input  logic [SAMPLE_WIDTH-1:0]     right_channel_audio_out,
    input  logic                        write_audio_out,
    output logic                        audio_out_allowed,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underflow,
    output logic                        overflow,
    input  logic                        AUD_BCLK,
    input  logic                        AUD_DACLRCK,
    output logic                        AUD_DACDAT
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(SLOT_WIDTH + 1);
    localparam int DW = 2 * SAMPLE_WIDTH;

    logic [1:0]              r_bclk_s, r_lrck_s;
    logic                    r_bclk_d, r_bfall, r_lrck_last, r_dacdat;
    logic [CW-1:0]           r_cnt;
    logic [DW-1:0]           r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wp, r_rp;
    logic [AW:0]             r_level;
    logic [SAMPLE_WIDTH-1:0] r_hold_l, r_hold_r;
    logic                    r_underflow, r_overflow;

    logic                    w_lrck, w_start, w_empty, w_full, w_pop, w_mute, w_push, w_in;
    logic [CW-1:0]           w_k, w_off;
    logic [DW-1:0]           w_head;
    logic [SAMPLE_WIDTH-1:0] w_cur_l, w_cur_r, w_word, w_sh;

    always_comb begin
        w_lrck  = r_lrck_s[1];
        w_start = r_bfall & (w_lrck != r_lrck_last);
        w_empty = r_level == '0;
        w_full  = r_level == (AW+1)'(FIFO_DEPTH);
        w_pop   = w_start & ~w_lrck & ~w_empty & ~clear_audio_out_memory;
        w_mute  = w_start & ~w_lrck & w_empty;
        w_push  = write_audio_out & (~w_full | w_pop) & ~clear_audio_out_memory;
        w_head  = r_mem[r_rp];
        // a left slot start serialises the pair being popped, not the stale holding register
        w_cur_l = clear_audio_out_memory ? '0 : w_pop ? w_head[DW-1:SAMPLE_WIDTH] : w_mute ? '0 : r_hold_l;
        w_cur_r = clear_audio_out_memory ? '0 : r_hold_r;
        w_word  = w_lrck ? w_cur_r : w_cur_l;
        w_k     = w_start ? '0 : r_cnt;
        // k below the I2S delay wraps w_off past SAMPLE_WIDTH, so one compare covers both bounds
        w_off   = w_k - CW'(I2S_MODE);
        w_in    = w_off < CW'(SAMPLE_WIDTH);
        w_sh    = w_word << w_off;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_bclk_s <= '0;
            r_lrck_s <= '0;
            r_bclk_d <= 1'b0;
            r_bfall  <= 1'b0;
        end else begin
            r_bclk_s <= {r_bclk_s[0], AUD_BCLK};
            r_lrck_s <= {r_lrck_s[0], AUD_DACLRCK};
            r_bclk_d <= r_bclk_s[1];
            r_bfall  <= r_bclk_d & ~r_bclk_s[1];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_lrck_last <= 1'b0;
            r_cnt       <= '0;
            r_dacdat    <= 1'b0;
        end else if (r_bfall) begin
            if (w_start) begin
                r_lrck_last <= w_lrck;
                r_cnt       <= CW'(1);
            end else begin
                r_cnt <= (r_cnt == CW'(SLOT_WIDTH)) ? r_cnt : r_cnt + CW'(1);
            end
            r_dacdat <= w_in & w_sh[SAMPLE_WIDTH-1];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_push)
            r_mem[r_wp] <= {left_channel_audio_out, right_channel_audio_out};
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_level     <= '0;
            r_hold_l    <= '0;
            r_hold_r    <= '0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (clear_audio_out_memory) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_level     <= '0;
            r_hold_l    <= '0;
            r_hold_r    <= '0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push)
                r_wp <= r_wp + AW'(1);
            if (w_pop) begin
                r_rp     <= r_rp + AW'(1);
                r_hold_l <= w_head[DW-1:SAMPLE_WIDTH];
                r_hold_r <= w_head[SAMPLE_WIDTH-1:0];
            end else if (w_mute) begin
                r_hold_l    <= '0;
                r_hold_r    <= '0;
                r_underflow <= 1'b1;
            end
            if (write_audio_out & w_full & ~w_pop)
                r_overflow <= 1'b1;
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    assign audio_out_allowed = ~w_full;
    assign fifo_level        = r_level;
    assign underflow         = r_underflow;
    assign overflow          = r_overflow;
    assign AUD_DACDAT        = r_dacdat;
endmodule
